// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the S x S result bus of the systolic array
// on a start pulse and streams the elements out over valid/ready, tagged with
// (row, col) and a last flag. The snapshot frees the array's Data bus for the
// next multiplication while the previous result is still being drained.
//
// Build option: define RESULT_TRANSPOSE_EN to stream column-major instead of
// row-major. out_row/out_col always report the true (i,j) of each element and
// out_last always marks element (S-1,S-1).

module systolic_result_drain #(
  parameter int S  = 4,
  parameter int M  = 5,
  localparam int IW = (S > 2) ? $clog2(S) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [M*S*S-1:0] Data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [M-1:0]     out_data,
  output logic [IW-1:0]    out_row,
  output logic [IW-1:0]    out_col,
  output logic             out_last,
  output logic             busy
);

  localparam int AW = (S * S > 2) ? $clog2(S * S) : 1;
  localparam logic [IW-1:0] IMAX = IW'(S - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state;
  logic [S*S-1:0][M-1:0]    snap;   // element (i,j) lives at index i*S+j
  logic [IW-1:0]            nrow, ncol;
  logic [AW-1:0]            sel;
  logic                     nlast;
  logic                     xfer;

  assign xfer = out_valid & out_ready;

  // Next element position in stream order, and its snapshot slot
  always_comb begin
    nrow = out_row;
    ncol = out_col;
`ifdef RESULT_TRANSPOSE_EN
    if (out_row == IMAX) begin
      nrow = '0;
      ncol = out_col + IW'(1);
    end else begin
      nrow = out_row + IW'(1);
    end
`else
    if (out_col == IMAX) begin
      ncol = '0;
      nrow = out_row + IW'(1);
    end else begin
      ncol = out_col + IW'(1);
    end
`endif
    sel   = AW'(nrow) * AW'(S) + AW'(ncol);
    nlast = (nrow == IMAX) && (ncol == IMAX);
  end

  // Drain FSM: capture on start, advance on each transfer, chain back-to-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRAIN;
            snap      <= Data;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_data  <= Data[M-1:0];   // element (0,0) of the new capture
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;          // S >= 2, so (0,0) is never last
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_last) begin
              out_row <= '0;
              out_col <= '0;
              if (start) begin
                // back-to-back matrix: no bubble between the two streams
                snap     <= Data;
                out_data <= Data[M-1:0];
                out_last <= 1'b0;
              end else begin
                // out_data keeps the last element's value while idle
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                out_last  <= 1'b0;
              end
            end else begin
              out_row  <= nrow;
              out_col  <= ncol;
              out_data <= snap[sel];
              out_last <= nlast;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (S=4, M=5). The reference
// model is a queue of pending (data,row,col,last) elements filled from the
// captured Data in stream order; the DUT is compared against its head.
// Define RESULT_TRANSPOSE_EN here too when building the transposed variant.

module tb_systolic_result_drain;

  localparam int S  = 4;
  localparam int M  = 5;
  localparam int IW = 2;
  localparam int DW = M * S * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] Data;
  logic          out_ready;
  logic          out_valid;
  logic [M-1:0]  out_data;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;
  logic          busy;

  systolic_result_drain #(.S(S), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .Data(Data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0]  d;
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          l;
  } elem_t;

  elem_t        q[$];
  logic [M-1:0] last_data;
  int           n_chk  = 0;
  int           n_fail = 0;

  function automatic logic [DW-1:0] pat(input int off);
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < S * S; k++) p[M*k +: M] = M'(k + off);
    return p;
  endfunction

  // Push a whole matrix into the model in stream order
  task automatic load(input logic [DW-1:0] d);
    elem_t e;
    int i, j;
    for (int k = 0; k < S * S; k++) begin
`ifdef RESULT_TRANSPOSE_EN
      i = k % S; j = k / S;
`else
      i = k / S; j = k % S;
`endif
      e.d = d[M*(i*S+j) +: M];
      e.r = IW'(i);
      e.c = IW'(j);
      e.l = (i == S - 1) && (j == S - 1);
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("busy",  32'(busy),      32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data", 32'(out_data), 32'(q[0].d));
      chk("row",  32'(out_row),  32'(q[0].r));
      chk("col",  32'(out_col),  32'(q[0].c));
      chk("last", 32'(out_last), 32'(q[0].l));
    end else begin
      chk("hold_data", 32'(out_data), 32'(last_data));
      chk("idle_row",  32'(out_row),  0);
      chk("idle_col",  32'(out_col),  0);
      chk("idle_last", 32'(out_last), 0);
    end
  endtask

  // Advance model by one clock using the inputs currently applied, then check
  task automatic tick();
    bit idle, xfer, wlast;
    elem_t e;
    if (rst) begin
      q.delete();
      last_data = '0;
    end else begin
      idle  = (q.size() == 0);
      xfer  = !idle && out_ready;
      wlast = 1'b0;
      if (xfer) begin
        e = q.pop_front();
        last_data = e.d;
        wlast = e.l;
      end
      if (start && (idle || wlast)) load(Data);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; Data = pat(0);
    last_data = '0;

    // reset / idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();

    // basic drain
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();

    // backpressure 1,0,0,1,...
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 44; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end

    // restart ignored mid-drain, then back-to-back start on last
    out_ready = 1'b1; start = 1'b1; Data = pat(0);
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (q.size() != 0 && q[0].d == 5) found = 1'b1; else tick();
    end
    chk("reach_5", 32'(found), 1);
    start = 1'b1; Data = '1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (q.size() != 0 && q[0].l) found = 1'b1; else tick();
    end
    chk("reach_last", 32'(found), 1);
    start = 1'b1; Data = pat(16);
    tick();
    start = 1'b0;
    chk("b2b_first", 32'(out_data), 16);
    repeat (18) tick();

    // mid-drain asynchronous reset
    start = 1'b1; Data = pat(0);
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (q.size() != 0 && q[0].d == 7) found = 1'b1; else tick();
    end
    chk("reach_7", 32'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_busy",  32'(busy), 0);
    chk("async_data",  32'(out_data), 0);
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();

    // random data, ready and start; Data churns every cycle
    for (int c = 0; c < 400; c++) begin
      Data      = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 5) == 0);
      tick();
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
